// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core and host request ports plus the data-memory port.
// The arbiter attaches as slave; the requesters and memory model attach as master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_prio;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_prio,
        input  mem_rdata,
        output core_ack, core_rdata, host_ack, host_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata, host_prio,
        output mem_rdata,
        input  core_ack, core_rdata, host_ack, host_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has default priority, host is guaranteed
// a slot after CORE_MAX_CONSEC consecutive core grants while it waits.
module dmem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CORE_MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RWAIT,
        S_ACK
    } state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_HOST
    } owner_t;

    localparam logic [3:0] MAX_STREAK = 4'(CORE_MAX_CONSEC);

    state_t            r_state;
    owner_t            r_owner;
    logic              r_we;
    logic [3:0]        r_streak;
    logic              r_busy;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_core_ack;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_any_req;
    logic              w_host_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic [3:0]        w_streak_next;

    // Host takes a tie only when prioritised or when the core has used up its streak.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        w_any_req   = bus.core_req | bus.host_req;
        w_host_win  = bus.host_req &
                      (~bus.core_req | bus.host_prio | (r_streak == MAX_STREAK));
        w_win_we    = bus.core_we;
        w_win_addr  = bus.core_addr;
        w_win_wdata = bus.core_wdata;
        if (w_host_win) begin
            w_win_we    = bus.host_we;
            w_win_addr  = bus.host_addr;
            w_win_wdata = bus.host_wdata;
        end

        w_streak_next = '0;
        if (!w_host_win && bus.host_req) begin
            w_streak_next = (r_streak == MAX_STREAK) ? r_streak : r_streak + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_CORE;
            r_we         <= 1'b0;
            r_streak     <= '0;
            r_busy       <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_ack   <= 1'b0;
            r_host_ack   <= 1'b0;
            // NOTE: read-data holding registers are outputs, so they are reset too.
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_core_ack <= 1'b0;
            r_host_ack <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_owner     <= w_host_win ? OWN_HOST : OWN_CORE;
                        r_we        <= w_win_we;
                        r_streak    <= w_streak_next;
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_wr    <= w_win_we;
                        r_mem_rd    <= ~w_win_we;
                    end
                end

                S_ISSUE: begin
                    if (r_we) begin
                        r_state    <= S_ACK;
                        r_core_ack <= (r_owner == OWN_CORE);
                        r_host_ack <= (r_owner == OWN_HOST);
                    end else begin
                        r_state <= S_RWAIT;
                    end
                end

                // Memory returns read data one cycle after the strobe.
                S_RWAIT: begin
                    r_state <= S_ACK;
                    if (r_owner == OWN_HOST) begin
                        r_host_rdata <= bus.mem_rdata;
                        r_host_ack   <= 1'b1;
                    end else begin
                        r_core_rdata <= bus.mem_rdata;
                        r_core_ack   <= 1'b1;
                    end
                end

                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_ack   = r_core_ack;
    assign bus.core_rdata = r_core_rdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.mem_rd     = r_mem_rd;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected accesses and responses,
// a negedge monitor pops and compares them as the arbiter produces strobes and acks.
module tb_dmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } op_t;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rd    = 0;
    int n_wr    = 0;
    int n_exp_acc = 0;

    acc_t        core_acc_q[$];
    acc_t        host_acc_q[$];
    logic [31:0] core_rsp_q[$];
    logic [31:0] host_rsp_q[$];
    int          core_ack_cyc[$];
    int          host_ack_cyc[$];
    bit          ack_log[$];
    op_t         core_ops[$];
    op_t         host_ops[$];

    logic [31:0] mem_model [0:255];
    acc_t        mon_acc;
    bit          mon_hit;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CORE_MAX_CONSEC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
            mem_model[8'h00] <= 32'h0000000A;
            mem_model[8'h01] <= 32'h0000000B;
            mem_model[8'h10] <= 32'h12345678;
            bus.mem_rdata    <= 32'h0;
        end else begin
            if (bus.mem_wr) mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
            if (bus.mem_rd) bus.mem_rdata <= mem_model[bus.mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_rd || bus.mem_wr) begin
            check("strobe_exclusive", {63'h0, bus.mem_rd & bus.mem_wr}, 64'h0);
            n_rd += int'(bus.mem_rd);
            n_wr += int'(bus.mem_wr);
            mon_acc.we    = bus.mem_wr;
            mon_acc.addr  = bus.mem_addr;
            mon_acc.wdata = bus.mem_wr ? bus.mem_wdata : 32'h0;
            mon_hit = 1'b0;
            if (core_acc_q.size() > 0 && core_acc_q[0] == mon_acc) begin
                void'(core_acc_q.pop_front());
                mon_hit = 1'b1;
            end else if (host_acc_q.size() > 0 && host_acc_q[0] == mon_acc) begin
                void'(host_acc_q.pop_front());
                mon_hit = 1'b1;
            end
            n_tests++;
            if (!mon_hit) begin
                n_fail++;
                $display("FAIL mem_access: got we=%0d addr=0x%0h wdata=0x%0h, no pending access matches (core pending=%0d host pending=%0d)",
                         mon_acc.we, mon_acc.addr, mon_acc.wdata, core_acc_q.size(), host_acc_q.size());
            end
        end
        if (bus.core_ack && bus.host_ack) check("ack_exclusive", 64'h1, 64'h0);
        if (bus.core_ack) begin
            core_ack_cyc.push_back(cyc);
            ack_log.push_back(1'b0);
            if (core_rsp_q.size() == 0) check("core_ack_unexpected", 64'h1, 64'h0);
            else check("core_rdata", bus.core_rdata, core_rsp_q.pop_front());
        end
        if (bus.host_ack) begin
            host_ack_cyc.push_back(cyc);
            ack_log.push_back(1'b1);
            if (host_rsp_q.size() == 0) check("host_ack_unexpected", 64'h1, 64'h0);
            else check("host_rdata", bus.host_rdata, host_rsp_q.pop_front());
        end
    end

    function automatic op_t mk_op(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_rdata);
        op_t op;
        op.we        = we;
        op.addr      = addr;
        op.wdata     = wdata;
        op.exp_rdata = exp_rdata;
        return op;
    endfunction

    function automatic void expect_op(input bit host, input op_t op);
        acc_t a;
        a.we    = op.we;
        a.addr  = op.addr;
        a.wdata = op.we ? op.wdata : 32'h0;
        if (host) begin
            host_acc_q.push_back(a);
            host_rsp_q.push_back(op.exp_rdata);
        end else begin
            core_acc_q.push_back(a);
            core_rsp_q.push_back(op.exp_rdata);
        end
        n_exp_acc++;
    endfunction

    task automatic drive(input bit host, input logic req, input op_t op);
        if (host) begin
            bus.host_req   = req;
            bus.host_we    = op.we;
            bus.host_addr  = op.addr;
            bus.host_wdata = op.wdata;
        end else begin
            bus.core_req   = req;
            bus.core_we    = op.we;
            bus.core_addr  = op.addr;
            bus.core_wdata = op.wdata;
        end
    endtask

    function automatic int pack_log();
        int v = 0;
        foreach (ack_log[i]) v = (v << 1) | int'(ack_log[i]);
        return v;
    endfunction

    function automatic void clear_logs();
        core_ack_cyc.delete();
        host_ack_cyc.delete();
        ack_log.delete();
    endfunction

    // Runs the queued ops of one requester back to back, re-requesting the cycle after ack.
    task automatic run_ops(input bit host, input int exp_lat);
        op_t op;
        int  lat;
        bit  got;
        bit  first = 1'b1;
        while ((host ? host_ops.size() : core_ops.size()) > 0) begin
            if (host) op = host_ops.pop_front();
            else      op = core_ops.pop_front();
            if (!first) begin
                @(posedge clk); #1;
            end
            first = 1'b0;
            expect_op(host, op);
            drive(host, 1'b1, op);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                @(posedge clk); #1;
                lat++;
                if (exp_lat > 0 && lat == 1) begin
                    check("issue_mem_wr", {63'h0, bus.mem_wr}, {63'h0, op.we});
                    check("issue_mem_rd", {63'h0, bus.mem_rd}, {63'h0, ~op.we});
                    check("issue_mem_addr", bus.mem_addr, op.addr);
                end
                got = host ? bus.host_ack : bus.core_ack;
            end
            check(host ? "host_ack_seen" : "core_ack_seen", {63'h0, got}, 64'h1);
            if (got && exp_lat > 0) check("ack_latency", lat, exp_lat);
        end
        @(posedge clk); #1;
        drive(host, 1'b0, mk_op(1'b0, 32'h0, 32'h0, 32'h0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        rst = 1'b1;
        bus.host_prio = 1'b0;
        drive(1'b0, 1'b0, mk_op(1'b0, 32'h0, 32'h0, 32'h0));
        drive(1'b1, 1'b0, mk_op(1'b0, 32'h0, 32'h0, 32'h0));
        idle(3);

        // Reset state
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_core_ack", {63'h0, bus.core_ack}, 64'h0);
        check("rst_host_ack", {63'h0, bus.host_ack}, 64'h0);
        check("rst_mem_rd", {63'h0, bus.mem_rd}, 64'h0);
        check("rst_mem_wr", {63'h0, bus.mem_wr}, 64'h0);
        check("rst_mem_addr", bus.mem_addr, 64'h0);
        check("rst_core_rdata", bus.core_rdata, 64'h0);
        check("rst_host_rdata", bus.host_rdata, 64'h0);
        rst = 1'b0;
        idle(1);

        // Core write alone: strobe at t+1, ack at t+2
        core_ops.push_back(mk_op(1'b1, 32'h10, 32'hDEADBEEF, 32'h0));
        run_ops(1'b0, 2);
        idle(2);

        // Host read: data at t+3, core read data untouched
        host_ops.push_back(mk_op(1'b0, 32'h40, 32'h0, 32'h12345678));
        run_ops(1'b1, 3);
        check("core_rdata_kept", bus.core_rdata, 64'h0);
        idle(2);

        // Back-to-back core reads
        clear_logs();
        rd0 = n_rd;
        core_ops.push_back(mk_op(1'b0, 32'h0, 32'h0, 32'hA));
        core_ops.push_back(mk_op(1'b0, 32'h4, 32'h0, 32'hB));
        run_ops(1'b0, 3);
        check("b2b_ack_count", core_ack_cyc.size(), 2);
        if (core_ack_cyc.size() == 2) check("b2b_ack_spacing", core_ack_cyc[1] - core_ack_cyc[0], 4);
        check("b2b_mem_rd_count", n_rd - rd0, 2);
        idle(2);

        // Starvation bound: core x4, host, core x4, host
        clear_logs();
        for (int i = 0; i < 8; i++)
            core_ops.push_back(mk_op(1'b1, 32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 32'hB));
        host_ops.push_back(mk_op(1'b1, 32'h200, 32'h4000_0001, 32'h12345678));
        host_ops.push_back(mk_op(1'b1, 32'h204, 32'h4000_0002, 32'h12345678));
        fork
            run_ops(1'b0, 0);
            run_ops(1'b1, 0);
        join
        check("starve_grant_count", ack_log.size(), 10);
        check("starve_grant_order", pack_log(), 32'h021);
        idle(2);

        // host_prio: host first, core acked 4 cycles later
        clear_logs();
        bus.host_prio = 1'b1;
        host_ops.push_back(mk_op(1'b0, 32'h40, 32'h0, 32'h12345678));
        core_ops.push_back(mk_op(1'b0, 32'h0, 32'h0, 32'hA));
        fork
            run_ops(1'b0, 0);
            run_ops(1'b1, 0);
        join
        bus.host_prio = 1'b0;
        check("prio_grant_count", ack_log.size(), 2);
        check("prio_grant_order", pack_log(), 32'h2);
        if (core_ack_cyc.size() == 1 && host_ack_cyc.size() == 1)
            check("prio_ack_spacing", core_ack_cyc[0] - host_ack_cyc[0], 4);
        idle(2);

        // Request dropped after one cycle: access still completes and acks
        expect_op(1'b1, mk_op(1'b1, 32'h80, 32'h55, 32'h12345678));
        drive(1'b1, 1'b1, mk_op(1'b1, 32'h80, 32'h55, 32'h0));
        idle(1);
        check("drop_mem_wr", {63'h0, bus.mem_wr}, 64'h1);
        bus.host_req = 1'b0;
        idle(1);
        check("drop_host_ack", {63'h0, bus.host_ack}, 64'h1);
        idle(2);

        // Reset during RWAIT of a core read
        core_acc_q.push_back(acc_t'{we: 1'b0, addr: 32'h4, wdata: 32'h0});
        n_exp_acc++;
        drive(1'b0, 1'b1, mk_op(1'b0, 32'h4, 32'h0, 32'h0));
        idle(1);
        check("rstmid_mem_rd", {63'h0, bus.mem_rd}, 64'h1);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("rstmid_busy", {63'h0, bus.busy}, 64'h0);
        check("rstmid_core_ack", {63'h0, bus.core_ack}, 64'h0);
        check("rstmid_host_ack", {63'h0, bus.host_ack}, 64'h0);
        check("rstmid_mem_rd", {63'h0, bus.mem_rd}, 64'h0);
        check("rstmid_core_rdata", bus.core_rdata, 64'h0);
        rst = 1'b0;
        bus.core_req = 1'b0;
        idle(1);
        core_ops.push_back(mk_op(1'b0, 32'h0, 32'h0, 32'hA));
        run_ops(1'b0, 3);
        idle(3);

        // Nothing left outstanding, and one strobe per issued access
        check("core_acc_left", core_acc_q.size(), 0);
        check("host_acc_left", host_acc_q.size(), 0);
        check("core_rsp_left", core_rsp_q.size(), 0);
        check("host_rsp_left", host_rsp_q.size(), 0);
        check("strobe_total", n_rd + n_wr, n_exp_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the SCC core's load/store path;
  - a host/debug port used for program load, memory inspection and test access.
- Sits between the core's data_memory_* signals and the external data memory.
- Issues one access at a time over a registered request/acknowledge handshake.
- Core has priority by default; a bounded-starvation counter guarantees host service.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.
- CORE_MAX_CONSEC, 4, consecutive core grants allowed while host is waiting before host is forced a slot (range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- core_req  in  1  core access request, held until core_ack.
- core_we  in  1  1=write, 0=read; stable while core_req.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  DATA_W  read data, valid in the core_ack cycle.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  same protocol as core.
- host_ack  out  1  host completion pulse.
- host_rdata  out  DATA_W  host read data, valid in the host_ack cycle.
- host_prio  in  1  1 = host wins every tie.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_rd.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; FSM=IDLE; owner=core; streak counter=0.
- FSM states and transitions:
  - IDLE -> ISSUE when any req=1.
  - ISSUE -> ACK on a write.
  - ISSUE -> RWAIT on a read.
  - RWAIT -> ACK.
  - ACK -> IDLE.
- IDLE arbitration (evaluated in the cycle req is sampled):
  - Only one requester → it wins.
  - Both requesting, host wins if host_prio=1 or streak==CORE_MAX_CONSEC.
  - Otherwise the core wins.
- On a win, latch owner, we, addr and wdata from the winner.
- ISSUE (one cycle): mem_addr/mem_wdata = latched values; mem_wr=we; mem_rd=!we. Strobes are 0 in all other states.
- RWAIT: capture mem_rdata into the owner's rdata register.
- ACK: owner's ack=1 for exactly one cycle. The other requester's ack stays 0.
- Latency (req first high in cycle t, arbiter idle):
  - write → mem_wr at t+1, ack at t+2;
  - read → mem_rd at t+1, mem_rdata sampled at end of t+2, ack and rdata at t+3.
- Requester rules:
  - Drop req, or present a new request, in the cycle after ack.
  - The IDLE cycle that follows ACK re-samples req. Minimum spacing is therefore 3 cycles per write and 4 per read.
- rdata register holds its value until that owner's next read completes. Writes do not alter rdata.
- Streak counter, updated at each IDLE grant:
  - core granted while host_req=1 → increment, saturating at CORE_MAX_CONSEC;
  - host granted, or host_req=0 → clear to 0.
- A request arriving while busy=1 waits; the arbiter never drops or reorders it.
- A req deasserted before ack is a protocol violation. The in-flight access still completes and ack is still pulsed.
- Reset mid-access:
  - next cycle IDLE, strobes 0, no ack;
  - a write already strobed in ISSUE may have landed in memory.

Test Plan:
- Core write alone: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF at t → mem_wr=1 with addr 0x10 and data 0xDEADBEEF at t+1; core_ack=1 at t+2; host_ack stays 0.
- Host read: mem returns 0x12345678 for addr 0x40 → mem_rd at t+1; host_ack=1 and host_rdata=0x12345678 at t+3; core_rdata unchanged.
- Starvation bound: core_req and host_req held high continuously (core re-requests after each ack), CORE_MAX_CONSEC=4, host_prio=0 → grant order core×4, host, core×4, host; streak returns to 0 after each host grant.
- host_prio=1 with both requesting → host granted first; core granted next IDLE; core_ack arrives 4 cycles after host_ack for back-to-back reads.
- Reset asserted during RWAIT of a core read → next cycle busy=0, all acks 0, mem_rd=0; a fresh core read afterwards completes at t+3 with correct data.
- Back-to-back core reads at addrs 0x0 and 0x4 (data 0xA, 0xB) → core_ack pulses 4 cycles apart; core_rdata=0xA then 0xB; exactly one mem_rd per access.
